inst_prefetch_queue: RTL and testbench

- Parametrised instruction prefetch unit that replaces the single-entry fetch register in inst_fetch.
- Issues in-order instruction reads to the instruction memory port with up to DEPTH requests outstanding, and buffers returned words in a DEPTH-entry FIFO.
- Presents {PC, INST} to decode under a valid/stall handshake.
- Supports redirect (FLUSH) from the branch/jump stage; responses already in flight at redirect time are discarded.

---
 rtl/inst_prefetch_queue.sv | 93 +++++++++
 tb/tb_inst_prefetch_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: in-order instruction prefetcher with a credit-limited request window
// feeding a DEPTH-entry {PC, INST} FIFO toward decode.
module inst_prefetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EXEC,
    input  logic                   FLUSH,
    input  logic [ADDR_W-1:0]      FLUSH_PC,
    output logic                   MEM_REQ,
    output logic [ADDR_W-1:0]      MEM_ADDR,
    input  logic                   MEM_ACK,
    input  logic                   MEM_RVALID,
    input  logic [DATA_W-1:0]      MEM_RDATA,
    input  logic                   STALL,
    output logic                   I_VALID,
    output logic [ADDR_W-1:0]      I_PC,
    output logic [DATA_W-1:0]      I_INST,
    output logic [$clog2(DEPTH):0] COUNT
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     count, inflight, inflight_nx, discard;
    logic [CW:0]       credit;
    logic [PW-1:0]     rd_ptr, wr_ptr, pq_rd, pq_wr;
    logic              accept, push, pop;
    logic [ADDR_W-1:0] pq        [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [DATA_W-1:0] fifo_inst [DEPTH];

    assign MEM_ADDR = pc;
    assign COUNT    = count;
    assign I_VALID  = count != '0;
    assign I_PC     = I_VALID ? fifo_pc[rd_ptr] : '0;
    assign I_INST   = I_VALID ? fifo_inst[rd_ptr] : '0;

    // Credit counts both buffered words and words still owed by memory, so a push never overflows.
    always_comb begin
        state_nx    = (state == IDLE && EXEC) ? RUN : (state == RUN && !EXEC) ? IDLE : state;
        credit      = {1'b0, count} + {1'b0, inflight};
        MEM_REQ     = (state == RUN) && (credit < LIMIT);
        accept      = MEM_REQ && MEM_ACK;
        push        = MEM_RVALID && (discard == '0) && !FLUSH;
        pop         = I_VALID && !STALL && !FLUSH;
        inflight_nx = inflight + CW'(accept) - CW'(MEM_RVALID);
    end

    // The PC queue is never cleared by a redirect: dropped responses still consume their entries.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pq_rd    <= '0;
            pq_wr    <= '0;
        end else begin
            assert (!(push && !pop && count == FULL));
            state    <= state_nx;
            inflight <= inflight_nx;
            pq_wr    <= pq_wr + PW'(accept);
            pq_rd    <= pq_rd + PW'(MEM_RVALID);
            pc       <= FLUSH ? FLUSH_PC : accept ? pc + ADDR_W'(4) : pc;
            discard  <= FLUSH ? inflight_nx : discard - CW'(MEM_RVALID && discard != '0);
            count    <= FLUSH ? '0 : count + CW'(push) - CW'(pop);
            wr_ptr   <= FLUSH ? '0 : wr_ptr + PW'(push);
            rd_ptr   <= FLUSH ? '0 : rd_ptr + PW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (accept)
            pq[pq_wr] <= pc;
        if (push) begin
            fifo_pc[wr_ptr]   <= pq[pq_rd];
            fifo_inst[wr_ptr] <= MEM_RDATA;
        end
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: scoreboard bench over a DEPTH=4, a DEPTH=2 and a wrapping-RESET_PC instance,
// each fed by its own fixed-latency in-order memory (RDATA = addr ^ 0xA5A5A5A5).
module tb_inst_prefetch_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  exec, flush, stall, ack_en;
    logic [31:0] flush_pc;
    logic [2:0]  mem_req, mem_ack, rvalid, i_valid;
    logic [31:0] mem_addr [3];
    logic [31:0] rdata    [3];
    logic [31:0] i_pc     [3];
    logic [31:0] i_inst   [3];
    logic [2:0]  cnt0, cnt2;
    logic [1:0]  cnt1;
    logic [31:0] exp_q [3][$];
    logic [31:0] exp_pc;
    int          lat, errors, checks, d0, d1, d2;
    int          nacc [3];
    int          ndel [3];

    always #5 clk = ~clk;

    inst_prefetch_queue u0 (
        .CLK(clk), .RST(rst_n), .EXEC(exec[0]), .FLUSH(flush[0]), .FLUSH_PC(flush_pc),
        .MEM_REQ(mem_req[0]), .MEM_ADDR(mem_addr[0]), .MEM_ACK(mem_ack[0]),
        .MEM_RVALID(rvalid[0]), .MEM_RDATA(rdata[0]), .STALL(stall[0]),
        .I_VALID(i_valid[0]), .I_PC(i_pc[0]), .I_INST(i_inst[0]), .COUNT(cnt0)
    );

    inst_prefetch_queue #(.DEPTH(2)) u1 (
        .CLK(clk), .RST(rst_n), .EXEC(exec[1]), .FLUSH(flush[1]), .FLUSH_PC(flush_pc),
        .MEM_REQ(mem_req[1]), .MEM_ADDR(mem_addr[1]), .MEM_ACK(mem_ack[1]),
        .MEM_RVALID(rvalid[1]), .MEM_RDATA(rdata[1]), .STALL(stall[1]),
        .I_VALID(i_valid[1]), .I_PC(i_pc[1]), .I_INST(i_inst[1]), .COUNT(cnt1)
    );

    inst_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u2 (
        .CLK(clk), .RST(rst_n), .EXEC(exec[2]), .FLUSH(flush[2]), .FLUSH_PC(flush_pc),
        .MEM_REQ(mem_req[2]), .MEM_ADDR(mem_addr[2]), .MEM_ACK(mem_ack[2]),
        .MEM_RVALID(rvalid[2]), .MEM_RDATA(rdata[2]), .STALL(stall[2]),
        .I_VALID(i_valid[2]), .I_PC(i_pc[2]), .I_INST(i_inst[2]), .COUNT(cnt2)
    );

    for (genvar g = 0; g < 3; g++) begin : mem
        logic [3:0]  v;
        logic [31:0] a [4];
        assign mem_ack[g] = mem_req[g] & ack_en[g];
        assign rvalid[g]  = v[0];
        assign rdata[g]   = a[0] ^ 32'hA5A5_A5A5;
        always @(posedge clk) begin
            if (!rst_n) begin
                v <= '0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    v[k] <= v[k+1];
                    a[k] <= a[k+1];
                end
                v[3] <= 1'b0;
                v[2'(lat-1)] <= mem_req[g] & mem_ack[g];
                a[2'(lat-1)] <= mem_addr[g];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Every word decode accepts is popped from that instance's scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (mem_req[i] && mem_ack[i])
                    nacc[i]++;
                if (i_valid[i] && !stall[i] && !flush[i]) begin
                    ndel[i]++;
                    chk($sformatf("u%0d_expected", i), 32'(exp_q[i].size() != 0), 32'd1);
                    if (exp_q[i].size() != 0) begin
                        exp_pc = exp_q[i].pop_front();
                        chk($sformatf("u%0d_pc", i), i_pc[i], exp_pc);
                        chk($sformatf("u%0d_inst", i), i_inst[i], exp_pc ^ 32'hA5A5_A5A5);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        exec   = '0;
        stall  = '0;
        flush  = '0;
        ack_en = '1;
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            nacc[i] = 0;
            ndel[i] = 0;
        end
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        lat      = 1;
        flush_pc = '0;
        do_reset();

        repeat (20) begin
            step();
            chk("rst_req", 32'(mem_req), 32'd0);
            chk("rst_valid", 32'(i_valid), 32'd0);
            chk("rst_count", 32'({cnt0, cnt1, cnt2}), 32'd0);
            chk("rst_addr0", mem_addr[0], 32'd0);
            chk("rst_addr2", mem_addr[2], 32'hFFFF_FFF8);
            chk("rst_ipc0", i_pc[0], 32'd0);
        end

        for (int k = 0; k < 60; k++) begin
            exp_q[0].push_back(32'(4 * k));
            exp_q[1].push_back(32'(4 * k));
            exp_q[2].push_back(32'hFFFF_FFF8 + 32'(4 * k));
        end
        exec = 3'b111;
        repeat (10) step();
        d0 = ndel[0];
        d1 = ndel[1];
        d2 = ndel[2];
        repeat (20) step();
        chk("stream_rate0", ndel[0] - d0, 32'd20);
        chk("stream_rate2", ndel[2] - d2, 32'd20);
        chk("stream_rate1_min", 32'(ndel[1] - d1 >= 12), 32'd1);

        #2 rst_n = 1'b0;
        #1;
        chk("async_req", 32'(mem_req), 32'd0);
        chk("async_valid", 32'(i_valid), 32'd0);
        chk("async_count0", 32'(cnt0), 32'd0);
        chk("async_addr0", mem_addr[0], 32'd0);
        chk("async_addr2", mem_addr[2], 32'hFFFF_FFF8);
        chk("async_ipc0", i_pc[0], 32'd0);
        chk("async_inst0", i_inst[0], 32'd0);

        do_reset();
        stall = 3'b011;
        exec  = 3'b011;
        for (int k = 0; k < 60; k++) begin
            exp_q[0].push_back(32'(4 * k));
            exp_q[1].push_back(32'(4 * k));
        end
        repeat (15) step();
        chk("bp_accepts0", nacc[0], 32'd4);
        chk("bp_accepts1", nacc[1], 32'd2);
        chk("bp_count0", 32'(cnt0), 32'd4);
        chk("bp_count1", 32'(cnt1), 32'd2);
        chk("bp_req", 32'(mem_req[1:0]), 32'd0);
        chk("bp_valid", 32'(i_valid[1:0]), 32'd3);
        chk("bp_ipc0", i_pc[0], 32'd0);
        chk("bp_ipc1", i_pc[1], 32'd0);
        stall = '0;
        repeat (30) step();
        chk("bp_drain0_min", 32'(ndel[0] >= 20), 32'd1);
        chk("bp_drain1_min", 32'(ndel[1] >= 12), 32'd1);
        exec = '0;
        repeat (8) step();
        chk("idle_count0", 32'(cnt0), 32'd0);
        chk("idle_req0", 32'(mem_req[0]), 32'd0);

        lat = 3;
        do_reset();
        exec[0] = 1'b1;
        repeat (3) step();
        chk("fl2_accepts", nacc[0], 32'd2);
        chk("fl2_req", 32'(mem_req[0]), 32'd1);
        ack_en[0] = 1'b0;
        flush[0]  = 1'b1;
        flush_pc  = 32'h0000_0100;
        for (int k = 0; k < 40; k++)
            exp_q[0].push_back(32'h100 + 32'(4 * k));
        step();
        chk("fl2_valid", 32'(i_valid[0]), 32'd0);
        chk("fl2_count", 32'(cnt0), 32'd0);
        chk("fl2_addr", mem_addr[0], 32'h0000_0100);
        flush[0]  = 1'b0;
        ack_en[0] = 1'b1;
        repeat (15) step();
        chk("fl2_delivered_min", 32'(ndel[0] >= 5), 32'd1);
        exec = '0;
        repeat (12) step();

        lat = 1;
        do_reset();
        exec[0] = 1'b1;
        for (int k = 0; k < 40; k++)
            exp_q[0].push_back(32'(4 * k));
        repeat (12) step();
        chk("flc_coincident", 32'(mem_req[0] & mem_ack[0] & rvalid[0]), 32'd1);
        d0       = ndel[0];
        flush[0] = 1'b1;
        flush_pc = 32'h0000_0200;
        exp_q[0].delete();
        for (int k = 0; k < 40; k++)
            exp_q[0].push_back(32'h200 + 32'(4 * k));
        step();
        chk("flc_valid", 32'(i_valid[0]), 32'd0);
        chk("flc_count", 32'(cnt0), 32'd0);
        chk("flc_addr", mem_addr[0], 32'h0000_0200);
        flush[0] = 1'b0;
        repeat (15) step();
        chk("flc_delivered_min", 32'(ndel[0] - d0 >= 10), 32'd1);
        exec = '0;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
